// File: rtl/sat_chan_pkg.sv
// sat_chan_pkg: shared constants, C/A tap table and LUT helper
// for the multi-channel GPS L1 C/A synthesizer.
package sat_chan_pkg;

  localparam logic [1:0] CFG_ADDR_CODE = 2'd0;
  localparam logic [1:0] CFG_ADDR_DOP  = 2'd1;
  localparam logic [1:0] CFG_ADDR_GAIN = 2'd2;
  localparam logic [1:0] CFG_ADDR_CTRL = 2'd3;

  localparam int CHIP_CNT     = 1023;
  localparam int CTRL_W       = 7;
  localparam int CTRL_EN_BIT  = 6;
  localparam int CTRL_SEL_MSB = 5;

  localparam real PI = 3.141592653589793;

  // {t1,t2} G2 stage taps, 0-based (stage n -> bit n-1)
  localparam logic [7:0] G2_TAPS [33] = '{
    8'h00,
    8'h15, 8'h26, 8'h37, 8'h48,
    8'h08, 8'h19, 8'h07, 8'h18,
    8'h29, 8'h12, 8'h23, 8'h45,
    8'h56, 8'h67, 8'h78, 8'h89,
    8'h03, 8'h14, 8'h25, 8'h36,
    8'h47, 8'h58, 8'h02, 8'h35,
    8'h46, 8'h57, 8'h68, 8'h79,
    8'h05, 8'h16, 8'h27, 8'h38
  };

  function automatic logic ca_sel_ok(
    input logic [5:0] sel
  );
    return (sel >= 6'd1) && (sel <= 6'd32);
  endfunction

  function automatic logic [7:0] g2_taps(
    input logic [5:0] sel
  );
    return ca_sel_ok(sel) ? G2_TAPS[sel] : 8'h00;
  endfunction

  // Rounded amp*cos/sin of table index, evaluated at elaboration.
  function automatic int lut_val(
    input int idx,
    input bit is_sin,
    input int aw,
    input int amp
  );
    real ph;
    real v;
    ph = 2.0 * PI * $itor(idx) / $itor(1 << aw);
    v  = is_sin ? $sin(ph) : $cos(ph);
    v  = v * $itor(amp);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(0.5 - v);
  endfunction

endpackage

// File: rtl/ca_code_gen.sv
// ca_code_gen: one channel's G1/G2 Gold-code LFSRs, chip counter
// and pending code-epoch flag.
module ca_code_gen
  import sat_chan_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       restart_i,
  input  logic       adv_i,
  input  logic       smp_i,
  input  logic [5:0] ca_sel_i,
  output logic       chip_o,
  output logic       sel_ok_o,
  output logic       epoch_o
);

  logic [9:0] g1_q, g1_d;
  logic [9:0] g2_q, g2_d;
  logic [9:0] cnt_q, cnt_d;
  logic       ep_q, ep_d;
  logic [7:0] taps;
  logic       wrap;

  assign taps     = g2_taps(ca_sel_i);
  assign sel_ok_o = ca_sel_ok(ca_sel_i);
  assign chip_o   = g1_q[9]
                  ^ g2_q[taps[7:4]]
                  ^ g2_q[taps[3:0]];
  assign wrap     = cnt_q == 10'(CHIP_CNT - 1);
  assign epoch_o  = ep_q;

  // Epoch flag marks the first sample of chip 0 until consumed.
  always_comb begin
    g1_d  = g1_q;
    g2_d  = g2_q;
    cnt_d = cnt_q;
    ep_d  = ep_q;
    if (smp_i) ep_d = 1'b0;
    if (adv_i) begin
      g1_d  = {g1_q[8:0], g1_q[2] ^ g1_q[9]};
      g2_d  = {g2_q[8:0],
               g2_q[1] ^ g2_q[2] ^ g2_q[5] ^
               g2_q[7] ^ g2_q[8] ^ g2_q[9]};
      cnt_d = wrap ? '0 : cnt_q + 10'd1;
      if (wrap) ep_d = 1'b1;
    end
    if (restart_i) begin
      g1_d  = '1;
      g2_d  = '1;
      cnt_d = '0;
      ep_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      g1_q  <= '1;
      g2_q  <= '1;
      cnt_q <= '0;
      ep_q  <= 1'b0;
    end else begin
      g1_q  <= g1_d;
      g2_q  <= g2_d;
      cnt_q <= cnt_d;
      ep_q  <= ep_d;
    end
  end

endmodule

// File: rtl/sat_chan_bank.sv
// sat_chan_bank: N-channel GPS L1 C/A baseband synthesizer with
// shadow/commit config and a saturating complex sum.
module sat_chan_bank
  import sat_chan_pkg::*;
#(
  parameter int N_CHAN     = 4,
  parameter int PHASE_W    = 32,
  parameter int LUT_ADDR_W = 10,
  parameter int OUT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    dv_in,
  input  logic                    cfg_we,
  input  logic [$clog2(N_CHAN > 1 ? N_CHAN : 2)-1:0] cfg_chan,
  input  logic [1:0]              cfg_addr,
  input  logic [31:0]             cfg_data,
  input  logic                    cfg_commit,
  output logic                    dv_out,
  output logic signed [OUT_W-1:0] real_out,
  output logic signed [OUT_W-1:0] imag_out,
  output logic [N_CHAN-1:0]       chan_epoch
);

  localparam int CH_W  = $clog2(N_CHAN > 1 ? N_CHAN : 2);
  localparam int LUT_N = 1 << LUT_ADDR_W;
  localparam int AMP   = (1 << (OUT_W - 1)) - 1;
  localparam int TW    = OUT_W + 2;
  localparam int SW    = OUT_W + $clog2(N_CHAN) + 2;
  localparam int PW    = OUT_W + 18;

  localparam logic signed [SW-1:0] SMAX =
    {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN =
    {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  function automatic logic signed [OUT_W-1:0] sat(
    input logic signed [SW-1:0] v
  );
    if (v > SMAX) return {1'b0, {(OUT_W-1){1'b1}}};
    if (v < SMIN) return {1'b1, {(OUT_W-1){1'b0}}};
    return v[OUT_W-1:0];
  endfunction

  logic signed [OUT_W-1:0] cos_rom [LUT_N];
  logic signed [OUT_W-1:0] sin_rom [LUT_N];

  for (genvar k = 0; k < LUT_N; k++) begin : g_rom
    assign cos_rom[k] =
      OUT_W'(lut_val(k, 1'b0, LUT_ADDR_W, AMP));
    assign sin_rom[k] =
      OUT_W'(lut_val(k, 1'b1, LUT_ADDR_W, AMP));
  end

  logic v1_q, v2_q, v3_q;

  logic signed [TW-1:0] term_re [N_CHAN];
  logic signed [TW-1:0] term_im [N_CHAN];
  logic [N_CHAN-1:0]    ep3;

  for (genvar i = 0; i < N_CHAN; i++) begin : g_ch
    logic [PHASE_W-1:0] sh_code_q, sh_code_d;
    logic [PHASE_W-1:0] sh_dop_q, sh_dop_d;
    logic [15:0]        sh_gain_q, sh_gain_d;
    logic [CTRL_W-1:0]  sh_ctrl_q, sh_ctrl_d;
    logic [PHASE_W-1:0] ac_code_q, ac_dop_q;
    logic [15:0]        ac_gain_q;
    logic [CTRL_W-1:0]  ac_ctrl_q;
    logic               dirty_q;
    logic               hit, wr_ctrl, restart;
    logic [PHASE_W-1:0] code_ph_q, car_ph_q, code_nxt;
    logic               carry, chip, sel_ok, ep_pend;

    logic [LUT_ADDR_W-1:0]   s1_addr_q;
    logic                    s1_neg_q, s1_act_q, s1_ep_q;
    logic [15:0]             s1_gain_q;
    logic signed [OUT_W-1:0] s2_cos_q, s2_sin_q;
    logic                    s2_neg_q, s2_act_q, s2_ep_q;
    logic [15:0]             s2_gain_q;
    logic signed [TW-1:0]    s3_re_q, s3_im_q;
    logic                    s3_ep_q;
    logic signed [OUT_W:0]   lre, lim;
    logic signed [PW-1:0]    pre, pim, gx;

    assign hit     = cfg_we && (cfg_chan == CH_W'(i));
    assign wr_ctrl = hit && (cfg_addr == CFG_ADDR_CTRL);
    assign restart = cfg_commit && (dirty_q || wr_ctrl);

    // The _d values let a same-cycle write ride along with commit.
    assign sh_code_d = (hit && cfg_addr == CFG_ADDR_CODE)
                     ? PHASE_W'(cfg_data) : sh_code_q;
    assign sh_dop_d  = (hit && cfg_addr == CFG_ADDR_DOP)
                     ? PHASE_W'(cfg_data) : sh_dop_q;
    assign sh_gain_d = (hit && cfg_addr == CFG_ADDR_GAIN)
                     ? cfg_data[15:0] : sh_gain_q;
    assign sh_ctrl_d = wr_ctrl
                     ? cfg_data[CTRL_W-1:0] : sh_ctrl_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sh_code_q <= '0;
        sh_dop_q  <= '0;
        sh_gain_q <= '0;
        sh_ctrl_q <= '0;
        ac_code_q <= '0;
        ac_dop_q  <= '0;
        ac_gain_q <= '0;
        ac_ctrl_q <= '0;
        dirty_q   <= 1'b0;
      end else begin
        sh_code_q <= sh_code_d;
        sh_dop_q  <= sh_dop_d;
        sh_gain_q <= sh_gain_d;
        sh_ctrl_q <= sh_ctrl_d;
        dirty_q   <= !cfg_commit && (dirty_q || wr_ctrl);
        if (cfg_commit) begin
          ac_code_q <= sh_code_d;
          ac_dop_q  <= sh_dop_d;
          ac_gain_q <= sh_gain_d;
          ac_ctrl_q <= sh_ctrl_d;
        end
      end
    end

    assign {carry, code_nxt} =
      {1'b0, code_ph_q} + {1'b0, ac_code_q};

    // Restart zeroes code phase only; carrier stays continuous.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        code_ph_q <= '0;
        car_ph_q  <= '0;
      end else begin
        if (dv_in) begin
          code_ph_q <= code_nxt;
          car_ph_q  <= car_ph_q + ac_dop_q;
        end
        if (restart) code_ph_q <= '0;
      end
    end

    ca_code_gen u_ca (
      .clk       (clk),
      .reset     (reset),
      .restart_i (restart),
      .adv_i     (dv_in && carry),
      .smp_i     (dv_in),
      .ca_sel_i  (ac_ctrl_q[CTRL_SEL_MSB:0]),
      .chip_o    (chip),
      .sel_ok_o  (sel_ok),
      .epoch_o   (ep_pend)
    );

    assign lre = s2_neg_q ? -(OUT_W+1)'(s2_cos_q)
                          :  (OUT_W+1)'(s2_cos_q);
    assign lim = s2_neg_q ? -(OUT_W+1)'(s2_sin_q)
                          :  (OUT_W+1)'(s2_sin_q);
    assign gx  = PW'($signed({1'b0, s2_gain_q}));
    assign pre = PW'(lre) * gx;
    assign pim = PW'(lim) * gx;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1_addr_q <= '0;
        s1_neg_q  <= 1'b0;
        s1_act_q  <= 1'b0;
        s1_ep_q   <= 1'b0;
        s1_gain_q <= '0;
        s2_cos_q  <= '0;
        s2_sin_q  <= '0;
        s2_neg_q  <= 1'b0;
        s2_act_q  <= 1'b0;
        s2_ep_q   <= 1'b0;
        s2_gain_q <= '0;
        s3_re_q   <= '0;
        s3_im_q   <= '0;
        s3_ep_q   <= 1'b0;
      end else begin
        if (dv_in) begin
          s1_addr_q <= car_ph_q[PHASE_W-1 -: LUT_ADDR_W];
          s1_neg_q  <= chip;
          s1_act_q  <= ac_ctrl_q[CTRL_EN_BIT] && sel_ok;
          s1_ep_q   <= ep_pend;
          s1_gain_q <= ac_gain_q;
        end
        if (v1_q) begin
          s2_cos_q  <= cos_rom[s1_addr_q];
          s2_sin_q  <= sin_rom[s1_addr_q];
          s2_neg_q  <= s1_neg_q;
          s2_act_q  <= s1_act_q;
          s2_ep_q   <= s1_ep_q;
          s2_gain_q <= s1_gain_q;
        end
        if (v2_q) begin
          s3_re_q <= s2_act_q ? TW'(pre >>> 15) : '0;
          s3_im_q <= s2_act_q ? TW'(pim >>> 15) : '0;
          s3_ep_q <= s2_ep_q;
        end
      end
    end

    assign term_re[i] = s3_re_q;
    assign term_im[i] = s3_im_q;
    assign ep3[i]     = s3_ep_q;
  end

  logic signed [SW-1:0] sum_re, sum_im;

  always_comb begin
    sum_re = '0;
    sum_im = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      sum_re = sum_re + SW'(term_re[i]);
      sum_im = sum_im + SW'(term_im[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      v3_q       <= 1'b0;
      dv_out     <= 1'b0;
      real_out   <= '0;
      imag_out   <= '0;
      chan_epoch <= '0;
    end else begin
      v1_q       <= dv_in;
      v2_q       <= v1_q;
      v3_q       <= v2_q;
      dv_out     <= v3_q;
      chan_epoch <= v3_q ? ep3 : '0;
      if (v3_q) begin
        real_out <= sat(sum_re);
        imag_out <= sat(sum_im);
      end
    end
  end

endmodule
